// File: rtl/sorter_loader.sv
// Sorter transmit front end: collects one 4- or 16-sample frame, then drives start and 4-lane beats.
// Optional done-wait watchdog is enabled by defining SORTER_LOADER_TIMEOUT_EN.
module sorter_loader #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       M,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             start,
  output logic [1:0]       M_out,
  output logic [WIDTH-1:0] d1,
  output logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] d3,
  output logic [WIDTH-1:0] d4,
  output logic             d_valid,
  input  logic             sorter_done,
  output logic             busy,
  output logic             mode_err,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_GAP,
    S_SEND,
    S_WAIT_DONE
  } state_t;

  state_t           state;
  logic [4:0]       count;
  logic [1:0]       beat;
  logic [WIDTH-1:0] frame_buf [16];

  logic       accept;
  logic       qam_now;
  logic       last_sample;
  logic [1:0] last_beat;
  logic [1:0] load_beat;
  logic       expired;

  assign accept      = in_valid && in_ready;
  // At the first sample the frame length comes from the live M input, later from the latched mode.
  assign qam_now     = (count == 5'd0) ? (M == 2'b01) : (M_out == 2'b01);
  assign last_sample = (count == (qam_now ? 5'd15 : 5'd3));
  assign last_beat   = (M_out == 2'b01) ? 2'd3 : 2'd0;
  assign load_beat   = (state == S_GAP) ? 2'd0 : beat + 2'd1;

`ifdef SORTER_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;

  assign expired = (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT_DONE) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign expired            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (accept) begin
      frame_buf[count[3:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FILL;
      count    <= '0;
      beat     <= '0;
      in_ready <= 1'b1;
      start    <= 1'b0;
      M_out    <= 2'b00;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      d4       <= '0;
      d_valid  <= 1'b0;
      busy     <= 1'b0;
      mode_err <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      start    <= 1'b0;
      mode_err <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        S_FILL: begin
          if (accept) begin
            if (count == 5'd0) begin
              M_out    <= M[1] ? 2'b00 : M;
              mode_err <= M[1];
            end
            if (last_sample) begin
              count    <= '0;
              state    <= S_START;
              start    <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end else begin
              count <= count + 5'd1;
            end
          end
        end
        S_START: begin
          state <= S_GAP;
        end
        S_GAP, S_SEND: begin
          if (state == S_SEND && beat == last_beat) begin
            state   <= S_WAIT_DONE;
            d_valid <= 1'b0;
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
            d4      <= '0;
          end else begin
            state   <= S_SEND;
            d_valid <= 1'b1;
            beat    <= load_beat;
            d1      <= frame_buf[{load_beat, 2'd0}];
            d2      <= frame_buf[{load_beat, 2'd1}];
            d3      <= frame_buf[{load_beat, 2'd2}];
            d4      <= frame_buf[{load_beat, 2'd3}];
          end
        end
        S_WAIT_DONE: begin
          // A done arriving in the expiry cycle takes precedence over the timeout pulse.
          if (sorter_done || expired) begin
            state    <= S_FILL;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            timeout  <= !sorter_done;
          end
        end
        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_loader.sv
// Self-checking bench for sorter_loader: directed frame table, random frames and reset/timeout corners.
module tb_sorter_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] M = 2'b00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       start;
  logic [1:0] M_out;
  logic [7:0] d1, d2, d3, d4;
  logic       d_valid;
  logic       sorter_done = 1'b0;
  logic       busy;
  logic       mode_err;
  logic       timeout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sorter_loader #(.WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .M(M), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .start(start), .M_out(M_out),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d_valid(d_valid),
    .sorter_done(sorter_done), .busy(busy), .mode_err(mode_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        m;
    logic [15:0][7:0]  s;
    int unsigned       delay;
    bit                early;
    bit                bp;
    logic [1:0]        exp_mout;
    bit                exp_err;
    int unsigned       exp_n;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_M_out"}, M_out, 0);
    check({tag, "_lanes"}, {d1, d2, d3, d4}, 0);
    check({tag, "_d_valid"}, d_valid, 0);
    check({tag, "_mode_err"}, mode_err, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  // Feeds one frame with random valid gaps, checks the start/gap/beat timeline and WAIT_DONE.
  // Returns at the first WAIT_DONE negedge (plus delay) when give_done is 0.
  task automatic run_frame(input logic [1:0] m, input logic [15:0][7:0] s, input int unsigned delay,
                           input bit early, input bit bp, input logic [1:0] exp_mout, input bit exp_err,
                           input int unsigned exp_n, input bit give_done);
    int unsigned idx = 0;
    int unsigned guard = 0;
    bit pend = 0;
    bit v;
    while (idx < exp_n && guard < 400) begin
      @(negedge clk);
      guard++;
      if (pend) begin
        check("mode_err", mode_err, exp_err);
        pend = 0;
      end
      check("fill_in_ready", in_ready, 1);
      check("fill_busy", busy, 0);
      v = ($urandom_range(3) != 0);
      in_valid = v;
      in_data = s[idx];
      M = (idx == 0) ? m : 2'($urandom);
      if (v && in_ready) begin
        if (idx == 0) pend = 1;
        idx++;
      end
    end
    if (idx < exp_n) begin
      check("fill_timeout", idx, exp_n);
      in_valid = 0;
      return;
    end
    @(negedge clk);
    in_valid = bp;
    in_data = 8'($urandom);
    M = 2'($urandom);
    check("start_pulse", start, 1);
    check("start_d_valid", d_valid, 0);
    check("start_in_ready", in_ready, 0);
    check("start_busy", busy, 1);
    check("M_out", M_out, exp_mout);
    @(negedge clk);
    check("gap_start", start, 0);
    check("gap_d_valid", d_valid, 0);
    check("gap_busy", busy, 1);
    for (int b = 0; b < int'(exp_n / 4); b++) begin
      @(negedge clk);
      sorter_done = early && (b == 0);
      check("beat_d_valid", d_valid, 1);
      check("beat_lanes", {d1, d2, d3, d4}, {s[4*b], s[4*b+1], s[4*b+2], s[4*b+3]});
      check("beat_start", start, 0);
      check("beat_in_ready", in_ready, 0);
    end
    @(negedge clk);
    sorter_done = 0;
    check("wait_d_valid", d_valid, 0);
    check("wait_lanes_zero", {d1, d2, d3, d4}, 0);
    check("wait_in_ready", in_ready, 0);
    check("wait_busy", busy, 1);
    if (early) begin
      repeat (3) begin
        @(negedge clk);
        check("early_done_ignored", in_ready, 0);
      end
    end
    repeat (delay) begin
      @(negedge clk);
      check("wait_hold", in_ready, 0);
    end
    if (give_done) begin
      in_valid = 0;
      sorter_done = 1;
      @(negedge clk);
      sorter_done = 0;
      check("done_in_ready", in_ready, 1);
      check("done_busy", busy, 0);
      check("done_timeout", timeout, 0);
    end
  endtask

  vec_t tbl[5];
  logic [15:0][7:0] rs;
  logic [1:0] rm;
  int unsigned waited;

  initial begin
    for (int i = 0; i < 16; i++) tbl[1].s[i] = 8'(i);
    tbl[0] = '{m: 2'b00, s: '0, delay: 0, early: 0, bp: 0, exp_mout: 2'b00, exp_err: 0, exp_n: 4};
    tbl[0].s[0] = 8'd10; tbl[0].s[1] = 8'd20; tbl[0].s[2] = 8'd1; tbl[0].s[3] = 8'd0;
    tbl[1].m = 2'b01; tbl[1].delay = 2; tbl[1].early = 0; tbl[1].bp = 0;
    tbl[1].exp_mout = 2'b01; tbl[1].exp_err = 0; tbl[1].exp_n = 16;
    tbl[2] = '{m: 2'b00, s: '0, delay: 1, early: 1, bp: 1, exp_mout: 2'b00, exp_err: 0, exp_n: 4};
    tbl[2].s[0] = 8'hAA; tbl[2].s[1] = 8'h55; tbl[2].s[2] = 8'hFF; tbl[2].s[3] = 8'h01;
    tbl[3] = '{m: 2'b01, s: '0, delay: 0, early: 1, bp: 1, exp_mout: 2'b01, exp_err: 0, exp_n: 16};
    for (int i = 0; i < 16; i++) tbl[3].s[i] = 8'(255 - 16 * i);
    tbl[4] = '{m: 2'b10, s: '0, delay: 3, early: 0, bp: 0, exp_mout: 2'b00, exp_err: 1, exp_n: 4};
    tbl[4].s[0] = 8'd7; tbl[4].s[1] = 8'd6; tbl[4].s[2] = 8'd5; tbl[4].s[3] = 8'd4;

    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    check_reset_outputs("reset");

    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].m, tbl[i].s, tbl[i].delay, tbl[i].early, tbl[i].bp,
                tbl[i].exp_mout, tbl[i].exp_err, tbl[i].exp_n, 1);

    // Reset after 7 of 16 QAM16 samples discards the partial frame.
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      M = 2'b01;
      in_valid = 1;
      in_data = 8'(100 + i);
      @(negedge clk);
    end
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    check_reset_outputs("midreset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (start !== 1'b0) check("midreset_no_start", start, 0);
    end
    check("midreset_idle_ready", in_ready, 1);
    run_frame(2'b00, tbl[0].s, 0, 0, 0, 2'b00, 0, 4, 1);

    // Random frames against the mode/length rules.
    for (int f = 0; f < 12; f++) begin
      rm = 2'($urandom);
      for (int i = 0; i < 16; i++) rs[i] = 8'($urandom);
      run_frame(rm, rs, $urandom_range(5), 1'($urandom), 1'($urandom),
                rm[1] ? 2'b00 : rm, rm[1], (rm == 2'b01) ? 16 : 4, 1);
    end

    // Reserved mode with no done: watchdog behaviour depends on the build.
    run_frame(2'b11, tbl[4].s, 0, 0, 0, 2'b00, 1, 4, 0);
    waited = 0;
`ifdef SORTER_LOADER_TIMEOUT_EN
    while (waited < 20) begin
      @(negedge clk);
      waited++;
      if (in_ready) break;
    end
    check("timeout_cycles", waited, 8);
    check("timeout_pulse", timeout, 1);
    check("timeout_busy", busy, 0);
    @(negedge clk);
    check("timeout_one_cycle", timeout, 0);
`else
    repeat (20) begin
      @(negedge clk);
      waited = waited + ((in_ready === 1'b0 && timeout === 1'b0) ? 1 : 0);
    end
    check("no_timeout_wait", waited, 20);
    sorter_done = 1;
    @(negedge clk);
    sorter_done = 0;
    check("late_done_in_ready", in_ready, 1);
    check("late_done_timeout", timeout, 0);
`endif
    run_frame(2'b01, tbl[1].s, 0, 0, 0, 2'b01, 0, 16, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
